// File: rtl/pal_ctrl.sv
// Bus-side sequencer for palette RAM port A: post-reset fill, then CPU cs/rw/dtack cycles.
// Define PAL_STE_COLOR_EN for 12-bit STE colours; undefined keeps the 9-bit ST palette.
module pal_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [11:0] INIT_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       din,
  output logic [15:0]       dout,
  output logic              dtack,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_we,
  input  logic [15:0]       ram_q
);

`ifdef PAL_STE_COLOR_EN
  localparam logic [11:0] COLOR_MASK = 12'hFFF;
`else
  localparam logic [11:0] COLOR_MASK = 12'h777;
`endif
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [15:0]       FILL_WORD = {4'b0000, INIT_COLOR & COLOR_MASK};

  typedef enum logic [2:0] {
    INIT, IDLE, RD_ADDR, RD_DATA, WR, ACK
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]       r_dout, w_dout_nxt;
  logic              r_dtack, w_dtack_nxt;
  logic              r_init_done, w_init_done_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [15:0]       r_ram_data, w_ram_data_nxt;
  logic              r_ram_we, w_ram_we_nxt;
  logic              w_unused_hi;

  // Upper nibbles of the bus and RAM words carry no colour information.
  assign w_unused_hi = ^{din[15:12], ram_q[15:12]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_dout      <= '0;
      r_dtack     <= 1'b0;
      r_init_done <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= FILL_WORD;
      r_ram_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dout      <= w_dout_nxt;
      r_dtack     <= w_dtack_nxt;
      r_init_done <= w_init_done_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_data  <= w_ram_data_nxt;
      r_ram_we    <= w_ram_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_dout_nxt      = r_dout;
    w_dtack_nxt     = r_dtack;
    w_init_done_nxt = r_init_done;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_data_nxt  = r_ram_data;
    w_ram_we_nxt    = 1'b0;
    case (r_state)
      INIT: begin
        // The last entry is on the port when we is high with addr at its maximum.
        if (r_ram_we && (r_ram_addr == ADDR_MAX)) begin
          w_init_done_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end else begin
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = r_cnt;
          w_ram_data_nxt = FILL_WORD;
          w_cnt_nxt      = r_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (cs) begin
          w_ram_addr_nxt = addr;
          if (rw) begin
            w_state_nxt = RD_ADDR;
          end else begin
            w_ram_data_nxt = {4'b0000, din[11:0] & COLOR_MASK};
            w_ram_we_nxt   = 1'b1;
            w_state_nxt    = WR;
          end
        end
      end
      RD_ADDR: w_state_nxt = RD_DATA;
      RD_DATA: begin
        w_dout_nxt  = {4'b0000, ram_q[11:0] & COLOR_MASK};
        w_dtack_nxt = 1'b1;
        w_state_nxt = ACK;
      end
      WR: begin
        w_dtack_nxt = 1'b1;
        w_state_nxt = ACK;
      end
      ACK: begin
        if (!cs) begin
          w_dtack_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  assign dout      = r_dout;
  assign dtack     = r_dtack;
  assign init_done = r_init_done;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_pal_ctrl.sv
// Self-checking bench for pal_ctrl with a behavioural dual-port palette RAM.
// Expected bus results go through a scoreboard queue; honours PAL_STE_COLOR_EN.
module tb_pal_ctrl;

`ifdef PAL_STE_COLOR_EN
  localparam logic [11:0] MASK = 12'hFFF;
`else
  localparam logic [11:0] MASK = 12'h777;
`endif
  localparam logic [11:0] INIT_C = 12'h000;

  logic        clk = 1'b0;
  logic        reset, cs, rw;
  logic [7:0]  addr;
  logic [15:0] din, dout, ram_data, ram_q;
  logic        dtack, init_done, ram_we;
  logic [7:0]  ram_addr;

  logic [15:0] mem [256];
  logic [11:0] shadow [256];

  typedef struct {
    logic        is_rd;
    logic [7:0]  a;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  pal_ctrl #(.ADDR_W(8), .INIT_COLOR(INIT_C)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .din(din),
    .dout(dout), .dtack(dtack), .init_done(init_done),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Port A: write plus one-cycle registered read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cs = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs the fill from reset release; ram_we expected on edges 1..256, init_done on edge 257.
  task automatic fill_check(input string tag);
    int cyc = 0, writes = 0, bad = 0, first = -1;
    while (!init_done && cyc < 400) begin
      tick();
      cyc++;
      if (ram_we) begin
        if (first < 0) first = cyc;
        if (ram_addr != 8'(writes) || cyc != first + writes) bad++;
        writes++;
      end
    end
    check({tag, "_first_we_edge"}, 32'(first), 32'd1);
    check({tag, "_order"}, 32'(bad), 32'd0);
    check({tag, "_writes"}, 32'(writes), 32'd256);
    check({tag, "_done_edge"}, 32'(cyc), 32'd257);
    check({tag, "_we_low"}, 32'(ram_we), 32'd0);
  endtask

  // One bus cycle. exp_lat counts edges with the cs-sampling edge as 1 (0 = skip).
  task automatic bus_op(input string tag, input logic rd, input logic [7:0] a,
                        input logic [15:0] d, input int exp_lat, input int hold,
                        input bit rst_at_end, output int o_n, output int o_idone_n);
    exp_t e, got;
    int n = 0, we_cnt = 0;
    logic [15:0] wdata = '0;
    logic [7:0]  waddr = '0;
    o_idone_n = -1;
    e.is_rd = rd;
    e.a = a;
    if (rd) e.data = {4'b0, shadow[a]};
    else begin
      e.data = {4'b0, d[11:0] & MASK};
      shadow[a] = d[11:0] & MASK;
    end
    sb.push_back(e);
    cs = 1'b1; rw = rd; addr = a; din = d;
    forever begin
      tick();
      n++;
      if (init_done && o_idone_n < 0) o_idone_n = n;
      if (ram_we && init_done) begin we_cnt++; wdata = ram_data; waddr = ram_addr; end
      if (dtack) break;
      if (n > 400) begin check({tag, "_timeout"}, 32'd0, 32'd1); break; end
    end
    // Scramble bus-side inputs; the cycle already latched its own.
    addr = ~a; din = ~d; rw = ~rd;
    o_n = n;
    got = sb.pop_front();
    if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (got.is_rd) begin
      check({tag, "_dout"}, 32'(dout), 32'(got.data));
      check({tag, "_dout_hi"}, 32'(dout[15:12]), 32'd0);
    end else begin
      check({tag, "_wdata"}, 32'(wdata), 32'(got.data));
      check({tag, "_waddr"}, 32'(waddr), 32'(got.a));
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      if (ram_we) we_cnt++;
      if (!dtack || (got.is_rd && dout != got.data)) begin
        check({tag, "_hold"}, {dtack, 15'd0, dout}, {1'b1, 15'd0, got.is_rd ? got.data : dout});
      end
    end
    check({tag, "_we_pulses"}, 32'(we_cnt), got.is_rd ? 32'd0 : 32'd1);
    if (rst_at_end) reset = 1'b1;
    cs = 1'b0;
    tick();
    check({tag, "_dtack_fall"}, 32'(dtack), 32'd0);
  endtask

  initial begin
    int n, idn, bad;
    reset = 1'b1; cs = 1'b0; rw = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = 16'hDEAD; shadow[i] = INIT_C & MASK; end
    tick();
    tick();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dtack", 32'(dtack), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'({4'b0, INIT_C & MASK}));
    check("rst_ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0;
    fill_check("fill");
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== {4'b0, INIT_C & MASK}) bad++;
    check("fill_portb", 32'(bad), 32'd0);

    // Write held pending through the fill is served right after init_done.
    do_reset();
    bus_op("early_wr", 1'b0, 8'h05, 16'h0F0F, 0, 0, 1'b0, n, idn);
    check("early_after_init", 32'(n - idn), 32'd2);
    bus_op("early_rd", 1'b1, 8'h05, 16'h0000, 3, 0, 1'b0, n, idn);

    bus_op("wr_ff", 1'b0, 8'hFF, 16'h0123, 2, 0, 1'b0, n, idn);
    bus_op("rd_ff", 1'b1, 8'hFF, 16'h0000, 3, 4, 1'b0, n, idn);

    bus_op("mask_wr", 1'b0, 8'h00, 16'hFFFF, 2, 0, 1'b0, n, idn);
    bus_op("mask_rd", 1'b1, 8'h00, 16'h0000, 3, 0, 1'b0, n, idn);
    bus_op("pat_wr", 1'b0, 8'h80, 16'hA5C3, 2, 0, 1'b0, n, idn);
    bus_op("pat_rd", 1'b1, 8'h80, 16'h0000, 3, 0, 1'b0, n, idn);

    bus_op("held_wr", 1'b0, 8'h10, 16'h0456, 2, 20, 1'b0, n, idn);
    bus_op("held_rd", 1'b1, 8'h10, 16'h0000, 3, 20, 1'b0, n, idn);

    // Reset during ACK of a read: drop dtack, restart the fill, lose the write.
    bus_op("mid_rd", 1'b1, 8'hFF, 16'h0000, 3, 2, 1'b1, n, idn);
    check("mid_init_done", 32'(init_done), 32'd0);
    check("mid_ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0;
    fill_check("refill");
    check("refill_ff", 32'(mem[255]), 32'({4'b0, INIT_C & MASK}));
    for (int i = 0; i < 256; i++) shadow[i] = INIT_C & MASK;
    bus_op("post_rd", 1'b1, 8'hFF, 16'h0000, 3, 0, 1'b0, n, idn);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
